aha_clock_switch_ctrl: RTL and testbench
========================================

// Module: aha_clock_switch_ctrl
// PURPOSE
//  Sequencer for a bank of NUM_CLKS glitch-free clock switch slices feeding one clock mux.
//  Accepts a software/PMU switch request and runs break-before-make: drop all slice REQs,
//  wait until every slice ACK is low, raise the target REQ, then wait for its ACK.
//  Runs on an always-on control clock; slice ACKs are asynchronous and synchronized here.
// PARAMETERS
//  NUM_CLKS     4     number of clock sources/slices (>=2)
//  SEL_W        2     width of select index, >= clog2(NUM_CLKS)
//  DEFAULT_SEL  0     source requested out of reset
//  TIMEOUT_W    10    width of ACK-wait timeout counter (only with CLK_SWITCH_TIMEOUT_EN)
// PORTS
//  CLK            in   1         always-on control clock
//  RESETn         in   1         asynchronous, active-low reset
//  SW_START       in   1         one-cycle switch request; sampled only in IDLE
//  SW_SEL         in   SEL_W     requested source index, sampled with SW_START
//  SLICE_REQ      out  NUM_CLKS  SELECT_REQ to each slice (registered)
//  SLICE_ACK      in   NUM_CLKS  SELECT_ACK from each slice (async to CLK)
//  CUR_SEL        out  SEL_W     currently targeted source index
//  SEL_VALID      out  1         target slice REQ and synced ACK both high
//  BUSY           out  1         FSM not in IDLE
//  SW_DONE        out  1         one-cycle pulse when a request completes/aborts
//  SW_ERR         out  1         sticky error; cleared when next SW_START accepted
// BEHAVIOUR
//  Reset: SLICE_REQ=1<<DEFAULT_SEL, CUR_SEL=DEFAULT_SEL, SEL_VALID=0, BUSY=1, SW_DONE=0,
//   SW_ERR=0, state=WAIT_ON (boot selects default clock without software).
//  ACK sync: each SLICE_ACK bit through 2 CLK flops -> ack_s; 2-cycle latency.
//  FSM:
//   IDLE     : SW_START & SW_SEL>=NUM_CLKS -> SW_ERR=1, SW_DONE pulse, stay IDLE.
//              SW_START & SW_SEL==CUR_SEL & SEL_VALID -> SW_DONE next cycle, no REQ change.
//              other SW_START -> latch SW_SEL into CUR_SEL, clear SW_ERR, -> DESELECT.
//              SW_START outside IDLE is ignored (no queueing).
//   DESELECT : SLICE_REQ<=0, SEL_VALID<=0; -> WAIT_OFF next cycle.
//   WAIT_OFF : stay until ack_s==0 (all bits); -> SELECT.
//   SELECT   : SLICE_REQ<=1<<CUR_SEL; -> WAIT_ON.
//   WAIT_ON  : stay until ack_s[CUR_SEL]; then SEL_VALID<=1, SW_DONE pulse, -> IDLE.
//  Never more than one SLICE_REQ bit high; never raise a REQ while any ack_s bit is high.
//  SW_DONE high exactly one cycle, coincident with entry to IDLE.
//  IDLE monitor: if ack_s[CUR_SEL] falls while REQ high, SEL_VALID<=0; if it rises, <=1.
//  Reset asserted mid-switch: all state returns to reset values immediately (async).
// CONFIGURATION
//  CLK_SWITCH_TIMEOUT_EN defined: TIMEOUT_W counter cleared on entry to WAIT_OFF/WAIT_ON,
//   increments each cycle there; at all-ones: SW_ERR=1, SW_DONE pulse, -> IDLE.
//   WAIT_OFF timeout leaves SLICE_REQ=0, SEL_VALID=0. WAIT_ON timeout keeps target REQ
//   high, SEL_VALID=0; IDLE monitor sets SEL_VALID if the ACK arrives later.
//  Not defined: no counter; WAIT_OFF/WAIT_ON wait indefinitely; SW_ERR only from bad index.
// STRUCTURE
//  Package aha_clock_switch_pkg: FSM state encoding (IDLE, DESELECT, WAIT_OFF, SELECT,
//   WAIT_ON), onehot-from-index function, default widths.
//  Sub-module aha_sync_2ff (1-bit 2-flop synchronizer, async active-low reset to 0),
//   instantiated NUM_CLKS times for SLICE_ACK.
// TESTING (bench models slices with per-source clocks of differing periods)
//  Reset release, DEFAULT_SEL=0 -> SLICE_REQ=4'b0001, SEL_VALID=1 ~2 CLK after slice ACK, SW_DONE pulses.
//  SW_START,SW_SEL=2 from src0 -> REQ 0001->0000; 0100 only after ack_s==0; SW_DONE once; CUR_SEL=2.
//  SW_START,SW_SEL=2 while CUR_SEL=2 valid -> no REQ toggle, SW_DONE next cycle, SW_ERR=0.
//  SW_SEL=5 with NUM_CLKS=4 -> SW_ERR=1, SW_DONE pulse, SLICE_REQ unchanged; next valid start clears SW_ERR.
//  TIMEOUT_EN, target clock stopped -> after 2^TIMEOUT_W-1 cycles SW_ERR=1, REQ held, SEL_VALID=0; clock restart -> SEL_VALID=1.
//  RESETn low during WAIT_ON, SW_START during BUSY -> REQ back to default onehot; mid-busy start ignored; onehot0 asserted always.

Source files
------------

// File: rtl/aha_clock_switch_ctrl_pkg.sv
// Shared definitions for the clock switch sequencer.
//   - sw_state_e      : sequencer state encoding
//   - onehot_from_idx : index to one-hot vector, up to MaxClks sources
//   - Def*            : default widths/sizes
package aha_clock_switch_pkg;

  localparam int unsigned DefNumClks  = 4;
  localparam int unsigned DefSelW     = 2;
  localparam int unsigned DefTimeoutW = 10;
  localparam int unsigned MaxClks     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StDeselect,
    StWaitOff,
    StSelect,
    StWaitOn
  } sw_state_e;

  // Callers truncate the result to their own source count.
  function automatic logic [MaxClks-1:0] onehot_from_idx(input int unsigned idx);
    logic [MaxClks-1:0] v;
    v = '0;
    if (idx < MaxClks) begin
      v[idx[4:0]] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/aha_clock_switch_ctrl_if.sv
// Handshake bundle between a switch requester / slice bank and the sequencer.
//   sw_start, sw_sel        : switch request (requester -> sequencer)
//   slice_ack               : per-slice SELECT_ACK, asynchronous (slices -> sequencer)
//   slice_req               : per-slice SELECT_REQ (sequencer -> slices)
//   cur_sel, sel_valid      : current target and its confirmed state
//   busy, sw_done, sw_err   : sequencer status
// Modports: master = requester/slice side, slave = sequencer.
interface aha_clock_switch_ctrl_if #(
  parameter int unsigned NUM_CLKS = 4,
  parameter int unsigned SEL_W    = 2
);
  logic                sw_start;
  logic [SEL_W-1:0]    sw_sel;
  logic [NUM_CLKS-1:0] slice_req;
  logic [NUM_CLKS-1:0] slice_ack;
  logic [SEL_W-1:0]    cur_sel;
  logic                sel_valid;
  logic                busy;
  logic                sw_done;
  logic                sw_err;

  modport master (
    output sw_start, sw_sel, slice_ack,
    input  slice_req, cur_sel, sel_valid, busy, sw_done, sw_err
  );

  modport slave (
    input  sw_start, sw_sel, slice_ack,
    output slice_req, cur_sel, sel_valid, busy, sw_done, sw_err
  );
endinterface

// File: rtl/aha_clock_switch_ctrl_sync_2ff.sv
// aha_sync_2ff: 1-bit two-flop synchronizer.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, output resets to 0
//   i_d     : asynchronous input
//   o_q     : synchronized output (2-cycle latency)
module aha_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/aha_clock_switch_ctrl.sv
// aha_clock_switch_ctrl: break-before-make sequencer for a bank of glitch-free clock
// switch slices. Drops every slice REQ, waits for all synchronized ACKs to go low,
// raises the target REQ and waits for its ACK. Out of reset it selects DEFAULT_SEL.
//   i_clk   : always-on control clock
//   i_rst_n : asynchronous active-low reset
//   bus     : aha_clock_switch_ctrl_if.slave (request, slice REQ/ACK, status)
// Optional feature: define CLK_SWITCH_TIMEOUT_EN to bound WAIT_OFF/WAIT_ON with a
// TIMEOUT_W-bit counter; at all-ones the request ends with SW_ERR set.
module aha_clock_switch_ctrl
  import aha_clock_switch_pkg::*;
#(
  parameter int unsigned NUM_CLKS    = DefNumClks,
  parameter int unsigned SEL_W       = DefSelW,
  parameter int unsigned DEFAULT_SEL = 0,
  parameter int unsigned TIMEOUT_W   = DefTimeoutW
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  aha_clock_switch_ctrl_if.slave bus
);

  localparam logic [NUM_CLKS-1:0] DefReq = NUM_CLKS'(onehot_from_idx(DEFAULT_SEL));
  localparam logic [SEL_W-1:0]    DefSel = SEL_W'(DEFAULT_SEL);

  logic [NUM_CLKS-1:0] w_ack_s;
  logic [NUM_CLKS-1:0] w_cur_onehot;
  logic                w_sel_bad;
  logic                w_tgt_ack;
  logic                w_tgt_req;
  logic                w_timeout;

  sw_state_e           r_state, w_state_d;
  logic [NUM_CLKS-1:0] r_req, w_req_d;
  logic [SEL_W-1:0]    r_cur_sel, w_cur_sel_d;
  logic                r_valid, w_valid_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_ack_sync
    aha_sync_2ff u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (bus.slice_ack[g]),
      .o_q     (w_ack_s[g])
    );
  end

  assign w_sel_bad    = 32'(bus.sw_sel) >= NUM_CLKS;
  assign w_cur_onehot = NUM_CLKS'(onehot_from_idx(32'(r_cur_sel)));
  assign w_tgt_ack    = |(w_ack_s & w_cur_onehot);
  assign w_tgt_req    = |(r_req & w_cur_onehot);

`ifdef CLK_SWITCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo_cnt, w_tmo_cnt_d;

  assign w_timeout = &r_tmo_cnt;

  // Restart on every entry into a wait state; count while waiting.
  always_comb begin
    w_tmo_cnt_d = r_tmo_cnt;
    if ((w_state_d != r_state) && ((w_state_d == StWaitOff) || (w_state_d == StWaitOn))) begin
      w_tmo_cnt_d = '0;
    end else if ((r_state == StWaitOff) || (r_state == StWaitOn)) begin
      w_tmo_cnt_d = r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_req_d     = r_req;
    w_cur_sel_d = r_cur_sel;
    w_valid_d   = r_valid;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
    unique case (r_state)
      StIdle: begin
        // Track the selected slice while idle; covers late ACKs after a timeout.
        if (w_tgt_req) begin
          w_valid_d = w_tgt_ack;
        end
        if (bus.sw_start) begin
          if (w_sel_bad) begin
            w_err_d  = 1'b1;
            w_done_d = 1'b1;
          end else if ((bus.sw_sel == r_cur_sel) && r_valid) begin
            w_err_d  = 1'b0;
            w_done_d = 1'b1;
          end else begin
            w_cur_sel_d = bus.sw_sel;
            w_err_d     = 1'b0;
            w_state_d   = StDeselect;
          end
        end
      end
      StDeselect: begin
        w_req_d   = '0;
        w_valid_d = 1'b0;
        w_state_d = StWaitOff;
      end
      StWaitOff: begin
        if (w_ack_s == '0) begin
          w_state_d = StSelect;
        end else if (w_timeout) begin
          w_err_d   = 1'b1;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      StSelect: begin
        w_req_d   = w_cur_onehot;
        w_state_d = StWaitOn;
      end
      StWaitOn: begin
        if (w_tgt_ack) begin
          w_valid_d = 1'b1;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else if (w_timeout) begin
          // Target REQ stays up; the idle monitor confirms a late ACK.
          w_err_d   = 1'b1;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StWaitOn;
      r_req     <= DefReq;
      r_cur_sel <= DefSel;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_req     <= w_req_d;
      r_cur_sel <= w_cur_sel_d;
      r_valid   <= w_valid_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  assign bus.slice_req = r_req;
  assign bus.cur_sel   = r_cur_sel;
  assign bus.sel_valid = r_valid;
  assign bus.busy      = (r_state != StIdle);
  assign bus.sw_done   = r_done;
  assign bus.sw_err    = r_err;

endmodule

// File: tb/tb_aha_clock_switch_ctrl.sv
// Bench for aha_clock_switch_ctrl with four modelled slices, each on its own clock.
// A slice raises/lowers its ACK two of its own clock edges after its REQ changes.
module tb_aha_clock_switch_ctrl;

  localparam int unsigned NClk = 4;
  localparam int unsigned SelW = 3;
  localparam int unsigned TmoW = 6;

  logic clk;
  logic rst_n;
  logic [NClk-1:0] src_run = 4'hf;
  logic sclk [NClk];
  logic s_meta [NClk];
  logic s_ack [NClk];
  logic [NClk-1:0] w_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int req_chg_total = 0;
  logic [NClk-1:0] prev_req;
  logic prev_done;

  aha_clock_switch_ctrl_if #(.NUM_CLKS(NClk), .SEL_W(SelW)) bus_if ();

  aha_clock_switch_ctrl #(
    .NUM_CLKS    (NClk),
    .SEL_W       (SelW),
    .DEFAULT_SEL (0),
    .TIMEOUT_W   (TmoW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NClk; g++) begin : g_src
    initial begin
      sclk[g] = 1'b0;
      forever begin
        #(3 + 2 * g);
        if (src_run[g]) sclk[g] = ~sclk[g];
      end
    end
    always @(posedge sclk[g] or negedge rst_n) begin
      if (!rst_n) begin
        s_meta[g] <= 1'b0;
        s_ack[g]  <= 1'b0;
      end else begin
        s_meta[g] <= bus_if.slice_req[g];
        s_ack[g]  <= s_meta[g];
      end
    end
    assign w_ack[g] = s_ack[g];
  end

  assign bus_if.slice_ack = w_ack;

  // Invariants: at most one REQ, no REQ rise while any ACK is up, one-cycle done.
  always @(negedge clk) begin
    int v;
    v = 0;
    if (rst_n) begin
      if (!$onehot0(bus_if.slice_req)) v++;
      if (((bus_if.slice_req & ~prev_req) != '0) && (w_ack != '0)) v++;
      if (bus_if.sw_done && prev_done) v++;
      if (bus_if.slice_req != prev_req) req_chg_total <= req_chg_total + 1;
    end
    viol      <= viol + v;
    prev_req  <= bus_if.slice_req;
    prev_done <= bus_if.sw_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Samples 1 time unit after each edge; cyc is the sample index of the first done.
  task automatic wait_done(input int budget, output int cyc, output int pulses);
    cyc    = -1;
    pulses = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus_if.sw_done) begin
        pulses++;
        if (cyc < 0) cyc = i;
      end
      if ((cyc >= 0) && (i >= cyc + 8)) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_txn(input logic [SelW-1:0] sel, input int budget,
                         output int cyc, output int pulses);
    bus_if.sw_start = 1'b1;
    bus_if.sw_sel   = sel;
    @(posedge clk);
    #1;
    bus_if.sw_start = 1'b0;
    wait_done(budget, cyc, pulses);
  endtask

  typedef struct {
    logic [SelW-1:0] sel;
    logic [NClk-1:0] req;
    logic [SelW-1:0] cur;
    logic            valid;
    logic            err;
    int              chg;
    logic            fast;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc, pulses, chg0, found;

    vecs[0] = '{3'd2, 4'b0100, 3'd2, 1'b1, 1'b0, 2, 1'b0};
    vecs[1] = '{3'd2, 4'b0100, 3'd2, 1'b1, 1'b0, 0, 1'b1};
    vecs[2] = '{3'd5, 4'b0100, 3'd2, 1'b1, 1'b1, 0, 1'b1};
    vecs[3] = '{3'd1, 4'b0010, 3'd1, 1'b1, 1'b0, 2, 1'b0};
    vecs[4] = '{3'd3, 4'b1000, 3'd3, 1'b1, 1'b0, 2, 1'b0};
    vecs[5] = '{3'd7, 4'b1000, 3'd3, 1'b1, 1'b1, 0, 1'b1};
    vecs[6] = '{3'd0, 4'b0001, 3'd0, 1'b1, 1'b0, 2, 1'b0};
    vecs[7] = '{3'd0, 4'b0001, 3'd0, 1'b1, 1'b0, 0, 1'b1};

    rst_n = 1'b0;
    bus_if.sw_start = 1'b0;
    bus_if.sw_sel   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(bus_if.slice_req), 32'b0001);
    check("rst_cur_sel", 32'(bus_if.cur_sel), 0);
    check("rst_valid", 32'(bus_if.sel_valid), 0);
    check("rst_busy", 32'(bus_if.busy), 1);
    check("rst_done", 32'(bus_if.sw_done), 0);
    check("rst_err", 32'(bus_if.sw_err), 0);

    rst_n = 1'b1;
    wait_done(60, cyc, pulses);
    check("boot_done_pulses", 32'(pulses), 1);
    check("boot_valid", 32'(bus_if.sel_valid), 1);
    check("boot_busy", 32'(bus_if.busy), 0);
    check("boot_req", 32'(bus_if.slice_req), 32'b0001);

    for (int k = 0; k < 8; k++) begin
      chg0 = req_chg_total;
      run_txn(vecs[k].sel, 100, cyc, pulses);
      check($sformatf("v%0d_done_pulses", k), 32'(pulses), 1);
      check($sformatf("v%0d_immediate", k), 32'(cyc == 0), 32'(vecs[k].fast));
      check($sformatf("v%0d_req", k), 32'(bus_if.slice_req), 32'(vecs[k].req));
      check($sformatf("v%0d_cur_sel", k), 32'(bus_if.cur_sel), 32'(vecs[k].cur));
      check($sformatf("v%0d_valid", k), 32'(bus_if.sel_valid), 32'(vecs[k].valid));
      check($sformatf("v%0d_err", k), 32'(bus_if.sw_err), 32'(vecs[k].err));
      check($sformatf("v%0d_busy", k), 32'(bus_if.busy), 0);
      check($sformatf("v%0d_req_changes", k), 32'(req_chg_total - chg0), 32'(vecs[k].chg));
    end

    // Second start while busy must be dropped.
    bus_if.sw_start = 1'b1;
    bus_if.sw_sel   = 3'd1;
    @(posedge clk);
    #1;
    bus_if.sw_start = 1'b0;
    @(posedge clk);
    #1;
    check("midbusy_busy", 32'(bus_if.busy), 1);
    bus_if.sw_start = 1'b1;
    bus_if.sw_sel   = 3'd3;
    @(posedge clk);
    #1;
    bus_if.sw_start = 1'b0;
    wait_done(100, cyc, pulses);
    check("midbusy_pulses", 32'(pulses), 1);
    check("midbusy_cur_sel", 32'(bus_if.cur_sel), 1);
    check("midbusy_req", 32'(bus_if.slice_req), 32'b0010);
    check("midbusy_idle", 32'(bus_if.busy), 0);

    // Reset while waiting for the new source's ACK.
    bus_if.sw_start = 1'b1;
    bus_if.sw_sel   = 3'd2;
    @(posedge clk);
    #1;
    bus_if.sw_start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus_if.slice_req == 4'b0100) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("midrst_reached_select", 32'(found), 1);
    check("midrst_waiting", 32'(bus_if.busy && !bus_if.sel_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(bus_if.slice_req), 32'b0001);
    check("midrst_cur_sel", 32'(bus_if.cur_sel), 0);
    check("midrst_busy", 32'(bus_if.busy), 1);
    check("midrst_valid", 32'(bus_if.sel_valid), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_done(60, cyc, pulses);
    check("midrst_boot_pulses", 32'(pulses), 1);
    check("midrst_boot_valid", 32'(bus_if.sel_valid), 1);
    check("midrst_boot_req", 32'(bus_if.slice_req), 32'b0001);

`ifdef CLK_SWITCH_TIMEOUT_EN
    // Target clock stopped: WAIT_ON times out, REQ stays up, late ACK revalidates.
    src_run[3] = 1'b0;
    run_txn(3'd3, 200, cyc, pulses);
    check("tmo_pulses", 32'(pulses), 1);
    check("tmo_late_enough", 32'(cyc >= (1 << TmoW)), 1);
    check("tmo_err", 32'(bus_if.sw_err), 1);
    check("tmo_req", 32'(bus_if.slice_req), 32'b1000);
    check("tmo_valid", 32'(bus_if.sel_valid), 0);
    check("tmo_busy", 32'(bus_if.busy), 0);
    src_run[3] = 1'b1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.sel_valid) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("tmo_late_ack_valid", 32'(found), 1);
    check("tmo_err_sticky", 32'(bus_if.sw_err), 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("invariant_violations", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
